turn_scheduler: RTL and testbench
=================================

Name: turn_scheduler

Overview:
- Turn-based game sequencer that decides which of two characters may act.
- Gates each character's is_in_turn and keycode, meters the movement budget, issues fire strobes and waits for projectile resolution.
- Tracks hit points and declares the winner.
- Sits between the keyboard keycode path and the two character movement blocks and the projectile block; runs once per frame on frame_clk.

Parameters:
- TURN_FRAMES, 600, maximum frames per turn (10 s at 60 Hz); range 2..1023
- MOVE_BUDGET, 120, frames of left/right movement allowed per turn; range 1..255
- HANDOFF_FRAMES, 30, dead frames between turns; range 1..255
- PROJ_TIMEOUT, 300, maximum frames waiting for proj_done; range 1..1023
- START_HP, 3, hit points per player at game start; range 1..15
- KEY_LEFT, 8'd80; KEY_RIGHT, 8'd79; KEY_FIRE, 8'd44; KEY_START, 8'd40

Ports:
- Reset  in  1  asynchronous, active-high
- frame_clk  in  1  frame-rate clock
- keycode  in  8  current key from keyboard interface
- proj_done  in  1  projectile has landed or left screen; level, sampled each edge
- hit_p1, hit_p2  in  1  projectile struck player 1 / player 2; valid with proj_done
- p1_in_turn, p2_in_turn  out  1  enable to each character block
- p1_keycode, p2_keycode  out  8  gated keycode to each character block
- fire_p1, fire_p2  out  1  one-frame launch strobe
- turn_timer  out  10  frames remaining in current turn
- move_left  out  8  movement frames remaining
- p1_hp, p2_hp  out  4  hit points
- winner  out  2  0 none, 1 P1, 2 P2, 3 draw
- state_o  out  3  encoded FSM state, for HUD and debug

Behaviour:
- Reset is asynchronous, active-high; clock is frame_clk. All logic changes on the posedge of frame_clk only.
- Reset values:
  - state IDLE; all counters 0
  - p1_hp = p2_hp = START_HP
  - winner 0; fire strobes 0; prev_key 0
- States (state_o encoding): IDLE=0, P1_TURN=1, P1_FIRE=2, P2_TURN=3, P2_FIRE=4, HANDOFF=5, GAME_OVER=6.
- Key-press edges: a start or fire press is detected only when keycode==KEY and prev_key!=KEY. prev_key is registered every edge, so a held key never retriggers.
- Combinational decode:
  - px_in_turn = (state==Px_TURN)
  - px_keycode = keycode when px_in_turn and move_left!=0 and keycode is KEY_LEFT or KEY_RIGHT; otherwise 0
- IDLE: start edge → P1_TURN; hp reloaded to START_HP, winner cleared.
- Entry to any TURN state: turn_timer := TURN_FRAMES, move_left := MOVE_BUDGET.
- In TURN, evaluated each edge in priority order:
  1. Fire edge → matching FIRE state; fire_px=1 for exactly that one registered cycle; proj counter := PROJ_TIMEOUT.
  2. Otherwise, turn_timer==1 → HANDOFF, turn_timer := 0.
  3. Otherwise turn_timer decrements; move_left decrements (saturating at 0) if keycode is KEY_LEFT or KEY_RIGHT.
- FIRE state:
  - Both in_turn outputs are 0.
  - Each edge: if proj_done=1, apply hits. If hit_px is set, px_hp decrements, saturating at 0; simultaneous hits are both applied on the same edge.
  - After hits:
    - both hp==0 → GAME_OVER, winner=3
    - p1_hp==0 → GAME_OVER, winner=2
    - p2_hp==0 → GAME_OVER, winner=1
    - otherwise → HANDOFF
  - If proj_done=0 and the proj counter reaches 1 → HANDOFF with no hits applied. Otherwise the counter decrements.
  - hit_p1 and hit_p2 are ignored outside FIRE states.
- HANDOFF:
  - Counter loaded with HANDOFF_FRAMES on entry; lasts exactly HANDOFF_FRAMES cycles.
  - Then goes to the opposite player's TURN. A last_player flag records who moved.
- GAME_OVER: outputs hold; start edge → P1_TURN with hp reloaded and winner cleared.
- Reset mid-turn or mid-flight aborts immediately to IDLE. An in-progress fire strobe is cleared.
- Widths:
  - All counters unsigned; no wrap below 0.
  - turn_timer is 10 bits and must hold TURN_FRAMES.

Test Plan (bench parameters: TURN_FRAMES=8, MOVE_BUDGET=3, HANDOFF_FRAMES=2, PROJ_TIMEOUT=16, START_HP=2):
- Reset, keycode=40 for 1 cycle → state 1 next edge; p1_in_turn=1; turn_timer=8; move_left=3; p1_hp=p2_hp=2.
- In P1_TURN, hold keycode=80 for 5 cycles → p1_keycode=80 for 3 cycles, then 0; move_left=0; p2_keycode=0 throughout.
- In P1_TURN, no keys → after exactly 8 cycles state=5; after 2 more cycles state=3, p2_in_turn=1.
- In P2_TURN, keycode=44 held for 4 cycles → fire_p2 high exactly 1 cycle, state=4; proj_done=1 with hit_p1=1 → p1_hp=1, state=5. Repeat the hit → p1_hp=0, state=6, winner=2.
- In FIRE state, proj_done held 0 → state=5 after 16 cycles; hp unchanged.
- p1_hp=p2_hp=1, proj_done=1 with hit_p1=hit_p2=1 → both hp=0, winner=3. Assert Reset mid-P2_TURN → state 0, all outputs 0, hp=2.

Source files
------------

// File: rtl/turn_scheduler.sv
// ============================================================================
// turn_scheduler : two-player turn sequencer with move budget, fire strobes,
//                  projectile wait, hit-point tracking and winner decision.
// Rev 1.0
// ============================================================================
`default_nettype none

module turn_scheduler #(
  parameter int unsigned TURN_FRAMES    = 600,
  parameter int unsigned MOVE_BUDGET    = 120,
  parameter int unsigned HANDOFF_FRAMES = 30,
  parameter int unsigned PROJ_TIMEOUT   = 300,
  parameter int unsigned START_HP       = 3,
  parameter logic [7:0]  KEY_LEFT       = 8'd80,
  parameter logic [7:0]  KEY_RIGHT      = 8'd79,
  parameter logic [7:0]  KEY_FIRE       = 8'd44,
  parameter logic [7:0]  KEY_START      = 8'd40
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       proj_done,
  input  logic       hit_p1,
  input  logic       hit_p2,
  output logic       p1_in_turn,
  output logic       p2_in_turn,
  output logic [7:0] p1_keycode,
  output logic [7:0] p2_keycode,
  output logic       fire_p1,
  output logic       fire_p2,
  output logic [9:0] turn_timer,
  output logic [7:0] move_left,
  output logic [3:0] p1_hp,
  output logic [3:0] p2_hp,
  output logic [1:0] winner,
  output logic [2:0] state_o
);

  localparam logic [9:0] c_TURN_FRAMES    = 10'(TURN_FRAMES);
  localparam logic [7:0] c_MOVE_BUDGET    = 8'(MOVE_BUDGET);
  localparam logic [7:0] c_HANDOFF_FRAMES = 8'(HANDOFF_FRAMES);
  localparam logic [9:0] c_PROJ_TIMEOUT   = 10'(PROJ_TIMEOUT);
  localparam logic [3:0] c_START_HP       = 4'(START_HP);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_P1_TURN   = 3'd1,
    S_P1_FIRE   = 3'd2,
    S_P2_TURN   = 3'd3,
    S_P2_FIRE   = 3'd4,
    S_HANDOFF   = 3'd5,
    S_GAME_OVER = 3'd6
  } state_t;

  state_t     r_state,      w_state;
  logic [7:0] r_prev_key;
  logic [9:0] r_turn_timer, w_turn_timer;
  logic [7:0] r_move_left,  w_move_left;
  logic [9:0] r_proj_cnt,   w_proj_cnt;
  logic [7:0] r_ho_cnt,     w_ho_cnt;
  logic [3:0] r_p1_hp,      w_p1_hp;
  logic [3:0] r_p2_hp,      w_p2_hp;
  logic [1:0] r_winner,     w_winner;
  logic       r_fire_p1,    w_fire_p1;
  logic       r_fire_p2,    w_fire_p2;
  logic       r_last_p2,    w_last_p2;

  logic       w_start_edge;
  logic       w_fire_edge;
  logic       w_lr_key;
  logic [3:0] w_p1_hp_hit;
  logic [3:0] w_p2_hp_hit;

  assign w_start_edge = (keycode == KEY_START) && (r_prev_key != KEY_START);
  assign w_fire_edge  = (keycode == KEY_FIRE)  && (r_prev_key != KEY_FIRE);
  assign w_lr_key     = (keycode == KEY_LEFT)  || (keycode == KEY_RIGHT);

  // Saturating hit application; only consumed in the FIRE states.
  assign w_p1_hp_hit = (hit_p1 && (r_p1_hp != 4'd0)) ? r_p1_hp - 4'd1 : r_p1_hp;
  assign w_p2_hp_hit = (hit_p2 && (r_p2_hp != 4'd0)) ? r_p2_hp - 4'd1 : r_p2_hp;

  always_comb begin
    w_state      = r_state;
    w_turn_timer = r_turn_timer;
    w_move_left  = r_move_left;
    w_proj_cnt   = r_proj_cnt;
    w_ho_cnt     = r_ho_cnt;
    w_p1_hp      = r_p1_hp;
    w_p2_hp      = r_p2_hp;
    w_winner     = r_winner;
    w_fire_p1    = 1'b0;
    w_fire_p2    = 1'b0;
    w_last_p2    = r_last_p2;

    case (r_state)
      S_IDLE, S_GAME_OVER: begin
        if (w_start_edge) begin
          w_state      = S_P1_TURN;
          w_turn_timer = c_TURN_FRAMES;
          w_move_left  = c_MOVE_BUDGET;
          w_p1_hp      = c_START_HP;
          w_p2_hp      = c_START_HP;
          w_winner     = 2'd0;
        end
      end

      S_P1_TURN, S_P2_TURN: begin
        if (w_fire_edge) begin
          w_state    = (r_state == S_P1_TURN) ? S_P1_FIRE : S_P2_FIRE;
          w_fire_p1  = (r_state == S_P1_TURN);
          w_fire_p2  = (r_state == S_P2_TURN);
          w_last_p2  = (r_state == S_P2_TURN);
          w_proj_cnt = c_PROJ_TIMEOUT;
        end else if (r_turn_timer == 10'd1) begin
          w_state      = S_HANDOFF;
          w_turn_timer = 10'd0;
          w_ho_cnt     = c_HANDOFF_FRAMES;
          w_last_p2    = (r_state == S_P2_TURN);
        end else begin
          w_turn_timer = r_turn_timer - 10'd1;
          if (w_lr_key && (r_move_left != 8'd0)) begin
            w_move_left = r_move_left - 8'd1;
          end
        end
      end

      S_P1_FIRE, S_P2_FIRE: begin
        if (proj_done) begin
          w_p1_hp = w_p1_hp_hit;
          w_p2_hp = w_p2_hp_hit;
          if ((w_p1_hp_hit == 4'd0) && (w_p2_hp_hit == 4'd0)) begin
            w_state  = S_GAME_OVER;
            w_winner = 2'd3;
          end else if (w_p1_hp_hit == 4'd0) begin
            w_state  = S_GAME_OVER;
            w_winner = 2'd2;
          end else if (w_p2_hp_hit == 4'd0) begin
            w_state  = S_GAME_OVER;
            w_winner = 2'd1;
          end else begin
            w_state  = S_HANDOFF;
            w_ho_cnt = c_HANDOFF_FRAMES;
          end
        end else if (r_proj_cnt == 10'd1) begin
          w_state  = S_HANDOFF;
          w_ho_cnt = c_HANDOFF_FRAMES;
        end else begin
          w_proj_cnt = r_proj_cnt - 10'd1;
        end
      end

      S_HANDOFF: begin
        if (r_ho_cnt == 8'd1) begin
          w_state      = r_last_p2 ? S_P1_TURN : S_P2_TURN;
          w_turn_timer = c_TURN_FRAMES;
          w_move_left  = c_MOVE_BUDGET;
        end else begin
          w_ho_cnt = r_ho_cnt - 8'd1;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_prev_key   <= 8'd0;
      r_turn_timer <= 10'd0;
      r_move_left  <= 8'd0;
      r_proj_cnt   <= 10'd0;
      r_ho_cnt     <= 8'd0;
      r_p1_hp      <= c_START_HP;
      r_p2_hp      <= c_START_HP;
      r_winner     <= 2'd0;
      r_fire_p1    <= 1'b0;
      r_fire_p2    <= 1'b0;
      r_last_p2    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_prev_key   <= keycode;
      r_turn_timer <= w_turn_timer;
      r_move_left  <= w_move_left;
      r_proj_cnt   <= w_proj_cnt;
      r_ho_cnt     <= w_ho_cnt;
      r_p1_hp      <= w_p1_hp;
      r_p2_hp      <= w_p2_hp;
      r_winner     <= w_winner;
      r_fire_p1    <= w_fire_p1;
      r_fire_p2    <= w_fire_p2;
      r_last_p2    <= w_last_p2;
    end
  end

  assign p1_in_turn = (r_state == S_P1_TURN);
  assign p2_in_turn = (r_state == S_P2_TURN);
  assign p1_keycode = (p1_in_turn && (r_move_left != 8'd0) && w_lr_key) ? keycode : 8'd0;
  assign p2_keycode = (p2_in_turn && (r_move_left != 8'd0) && w_lr_key) ? keycode : 8'd0;
  assign fire_p1    = r_fire_p1;
  assign fire_p2    = r_fire_p2;
  assign turn_timer = r_turn_timer;
  assign move_left  = r_move_left;
  assign p1_hp      = r_p1_hp;
  assign p2_hp      = r_p2_hp;
  assign winner     = r_winner;
  assign state_o    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_turn_scheduler.sv
// ============================================================================
// tb_turn_scheduler : directed bench with a game-rule model and per-cycle compare.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_turn_scheduler;

  localparam int TF = 8;
  localparam int MB = 3;
  localparam int HF = 2;
  localparam int PT = 16;
  localparam int SH = 2;

  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic       proj_done, hit_p1, hit_p2;
  logic       p1_in_turn, p2_in_turn, fire_p1, fire_p2;
  logic [7:0] p1_keycode, p2_keycode, move_left;
  logic [9:0] turn_timer;
  logic [3:0] p1_hp, p2_hp;
  logic [1:0] winner;
  logic [2:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;

  turn_scheduler #(
    .TURN_FRAMES(TF), .MOVE_BUDGET(MB), .HANDOFF_FRAMES(HF),
    .PROJ_TIMEOUT(PT), .START_HP(SH),
    .KEY_LEFT(8'd80), .KEY_RIGHT(8'd79), .KEY_FIRE(8'd44), .KEY_START(8'd40)
  ) dut (
    .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .proj_done(proj_done), .hit_p1(hit_p1), .hit_p2(hit_p2),
    .p1_in_turn(p1_in_turn), .p2_in_turn(p2_in_turn),
    .p1_keycode(p1_keycode), .p2_keycode(p2_keycode),
    .fire_p1(fire_p1), .fire_p2(fire_p2),
    .turn_timer(turn_timer), .move_left(move_left),
    .p1_hp(p1_hp), .p2_hp(p2_hp), .winner(winner), .state_o(state_o)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // Game-rule model: phase 0 idle, 1/3 turn, 2/4 flight, 5 handoff, 6 over.
  typedef struct packed {
    int st; int tt; int ml; int pc; int hc;
    int h1; int h2; int win; int f1; int f2; int prev; int last;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r = '0;
    r.h1 = SH;
    r.h2 = SH;
    return r;
  endfunction

  function automatic model_t model_next(model_t c, int k, bit pd, bit a1, bit a2);
    model_t n;
    bit start_e, fire_e;
    n = c;
    start_e = (k == 40) && (c.prev != 40);
    fire_e  = (k == 44) && (c.prev != 44);
    n.f1 = 0;
    n.f2 = 0;
    if (c.st == 0 || c.st == 6) begin
      if (start_e) begin
        n.st = 1; n.tt = TF; n.ml = MB; n.h1 = SH; n.h2 = SH; n.win = 0;
      end
    end else if (c.st == 1 || c.st == 3) begin
      if (fire_e) begin
        n.f1 = (c.st == 1) ? 1 : 0;
        n.f2 = (c.st == 3) ? 1 : 0;
        n.last = (c.st == 3) ? 2 : 1;
        n.st = c.st + 1;
        n.pc = PT;
      end else if (c.tt == 1) begin
        n.last = (c.st == 3) ? 2 : 1;
        n.st = 5; n.tt = 0; n.hc = HF;
      end else begin
        n.tt = c.tt - 1;
        if ((k == 80 || k == 79) && c.ml > 0) n.ml = c.ml - 1;
      end
    end else if (c.st == 2 || c.st == 4) begin
      if (pd) begin
        if (a1 && c.h1 > 0) n.h1 = c.h1 - 1;
        if (a2 && c.h2 > 0) n.h2 = c.h2 - 1;
        if (n.h1 == 0 || n.h2 == 0) begin
          n.st = 6;
          n.win = (n.h1 == 0 && n.h2 == 0) ? 3 : (n.h1 == 0) ? 2 : 1;
        end else begin
          n.st = 5; n.hc = HF;
        end
      end else if (c.pc == 1) begin
        n.st = 5; n.hc = HF;
      end else begin
        n.pc = c.pc - 1;
      end
    end else if (c.st == 5) begin
      if (c.hc == 1) begin
        n.st = (c.last == 2) ? 1 : 3; n.tt = TF; n.ml = MB;
      end else begin
        n.hc = c.hc - 1;
      end
    end
    n.prev = k;
    return n;
  endfunction

  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) m <= model_reset();
    else       m <= model_next(m, int'(keycode), proj_done, hit_p1, hit_p2);
  end

  function automatic logic [50:0] pack_out(int st, bit it1, bit it2, int k1, int k2,
                                           int f1, int f2, int tt, int ml, int h1,
                                           int h2, int win);
    return {3'(st), it1, it2, 8'(k1), 8'(k2), 1'(f1), 1'(f2), 10'(tt), 8'(ml),
            4'(h1), 4'(h2), 2'(win)};
  endfunction

  // Per-cycle compare of every output against the model, away from the edge.
  always @(negedge frame_clk) begin
    logic [50:0] exp_v, act_v;
    int k1, k2;
    bit lr;
    lr = (keycode == 8'd80) || (keycode == 8'd79);
    k1 = (m.st == 1 && m.ml != 0 && lr) ? int'(keycode) : 0;
    k2 = (m.st == 3 && m.ml != 0 && lr) ? int'(keycode) : 0;
    exp_v = pack_out(m.st, m.st == 1, m.st == 3, k1, k2, m.f1, m.f2, m.tt, m.ml,
                     m.h1, m.h2, m.win);
    act_v = {state_o, p1_in_turn, p2_in_turn, p1_keycode, p2_keycode, fire_p1,
             fire_p2, turn_timer, move_left, p1_hp, p2_hp, winner};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL model_cycle t=%0t actual=%h required=%h", $time, act_v, exp_v);
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic [7:0] k, input logic pd, input logic a1, input logic a2);
    @(posedge frame_clk);
    #2;
    keycode = k; proj_done = pd; hit_p1 = a1; hit_p2 = a2;
    #1;
  endtask

  initial begin
    Reset = 1'b1; keycode = 8'd0; proj_done = 1'b0; hit_p1 = 1'b0; hit_p2 = 1'b0;
    @(posedge frame_clk);
    #3;
    chk("rst_state", 16'(state_o), 16'd0);
    chk("rst_p1_hp", 16'(p1_hp), 16'd2);
    chk("rst_p2_hp", 16'(p2_hp), 16'd2);
    chk("rst_timer", 16'(turn_timer), 16'd0);
    Reset = 1'b0;

    step(8'd40, 0, 0, 0);
    step(8'd0, 0, 0, 0);
    chk("start_state", 16'(state_o), 16'd1);
    chk("start_in_turn", 16'(p1_in_turn), 16'd1);
    chk("start_timer", 16'(turn_timer), 16'd8);
    chk("start_move", 16'(move_left), 16'd3);
    chk("start_hp", {p1_hp, p2_hp}, 16'h0022);

    for (int i = 0; i < 5; i++) begin
      step(8'd80, 0, 0, 0);
      chk("move_p1_key", 16'(p1_keycode), (i < 3) ? 16'd80 : 16'd0);
      chk("move_p2_key", 16'(p2_keycode), 16'd0);
    end
    step(8'd0, 0, 0, 0);
    chk("move_exhausted", 16'(move_left), 16'd0);
    step(8'd0, 0, 0, 0);
    step(8'd0, 0, 0, 0);
    chk("timeout_handoff", 16'(state_o), 16'd5);
    step(8'd0, 0, 0, 0);
    step(8'd0, 0, 0, 0);
    chk("p2_turn", 16'(state_o), 16'd3);
    chk("p2_in_turn", 16'(p2_in_turn), 16'd1);

    for (int i = 0; i < 7; i++) step(8'd0, 0, 0, 0);
    chk("p2_last_frame", 16'(state_o), 16'd3);
    step(8'd0, 0, 0, 0);
    chk("p2_timeout_8", 16'(state_o), 16'd5);
    step(8'd0, 0, 0, 0);
    step(8'd0, 0, 0, 0);
    chk("back_to_p1", 16'(state_o), 16'd1);

    step(8'd44, 0, 0, 0);
    step(8'd0, 0, 0, 0);
    chk("p1_fire_state", 16'(state_o), 16'd2);
    chk("p1_fire_strobe", 16'(fire_p1), 16'd1);
    step(8'd0, 0, 0, 0);
    chk("p1_fire_strobe_off", 16'(fire_p1), 16'd0);
    for (int i = 0; i < 14; i++) step(8'd0, 0, 0, 0);
    chk("proj_wait_15", 16'(state_o), 16'd2);
    step(8'd0, 0, 0, 0);
    chk("proj_timeout_16", 16'(state_o), 16'd5);
    chk("proj_timeout_hp", {p1_hp, p2_hp}, 16'h0022);
    step(8'd0, 0, 0, 0);
    step(8'd0, 0, 0, 0);

    step(8'd44, 0, 0, 0);
    chk("p2_pre_fire", 16'(fire_p2), 16'd0);
    step(8'd44, 0, 0, 0);
    chk("p2_fire_state", 16'(state_o), 16'd4);
    chk("p2_fire_strobe", 16'(fire_p2), 16'd1);
    step(8'd44, 0, 0, 0);
    chk("p2_fire_held_1", 16'(fire_p2), 16'd0);
    step(8'd44, 0, 0, 0);
    step(8'd0, 1, 1, 0);
    chk("p2_flight", 16'(state_o), 16'd4);
    step(8'd0, 0, 0, 0);
    chk("hit1_p1_hp", 16'(p1_hp), 16'd1);
    chk("hit1_state", 16'(state_o), 16'd5);
    step(8'd0, 0, 0, 0);
    step(8'd0, 0, 0, 0);

    step(8'd44, 0, 0, 0);
    step(8'd0, 1, 0, 0);
    step(8'd0, 0, 0, 0);
    chk("miss_state", 16'(state_o), 16'd5);
    chk("miss_hp", {p1_hp, p2_hp}, 16'h0012);
    step(8'd0, 0, 0, 0);
    step(8'd0, 0, 0, 0);

    step(8'd44, 0, 0, 0);
    step(8'd0, 1, 1, 0);
    step(8'd0, 0, 0, 0);
    chk("kill_p1_hp", 16'(p1_hp), 16'd0);
    chk("kill_state", 16'(state_o), 16'd6);
    chk("kill_winner", 16'(winner), 16'd2);
    step(8'd0, 1, 1, 1);
    chk("over_hold", {4'(state_o), 2'(winner)}, {4'd6, 2'd2});

    step(8'd40, 0, 0, 0);
    step(8'd0, 0, 0, 0);
    chk("restart_state", 16'(state_o), 16'd1);
    chk("restart_hp_win", {p1_hp, p2_hp, 2'(winner)}, {4'd2, 4'd2, 2'd0});

    step(8'd44, 0, 0, 0);
    step(8'd0, 1, 0, 1);
    step(8'd0, 0, 0, 0);
    step(8'd0, 0, 0, 0);
    step(8'd0, 0, 0, 0);
    step(8'd44, 0, 0, 0);
    step(8'd0, 1, 1, 0);
    step(8'd0, 0, 0, 0);
    chk("both_at_1", {p1_hp, p2_hp}, 16'h0011);
    step(8'd0, 0, 0, 0);
    step(8'd0, 0, 0, 0);
    step(8'd44, 0, 0, 0);
    step(8'd0, 1, 1, 1);
    step(8'd0, 0, 0, 0);
    chk("draw_hp", {p1_hp, p2_hp}, 16'h0000);
    chk("draw_winner", 16'(winner), 16'd3);
    chk("draw_state", 16'(state_o), 16'd6);

    step(8'd40, 0, 0, 0);
    step(8'd0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(8'd0, 0, 0, 0);
    chk("reset_pre_p2", 16'(state_o), 16'd3);
    step(8'd80, 0, 0, 0);
    chk("reset_pre_key", 16'(p2_keycode), 16'd80);
    #1;
    Reset = 1'b1;
    #1;
    chk("abort_state", 16'(state_o), 16'd0);
    chk("abort_in_turn", {p1_in_turn, p2_in_turn, fire_p1, fire_p2}, 16'd0);
    chk("abort_keys", {p1_keycode, p2_keycode}, 16'd0);
    chk("abort_counters", {6'(turn_timer), 8'(move_left)}, 16'd0);
    chk("abort_hp_win", {p1_hp, p2_hp, 2'(winner)}, {4'd2, 4'd2, 2'd0});
    @(posedge frame_clk);
    #2;
    Reset = 1'b0;
    step(8'd0, 0, 0, 0);
    step(8'd0, 0, 0, 0);
    chk("idle_after_abort", 16'(state_o), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
